// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction fields and memory/flag handshakes in, datapath controls out.
// Signal suffixes are from the control unit's point of view (_i driven by the environment).
//   type_i/op_i       instruction class and opcode from the instruction register
//   im_ready_i        instruction memory has fetched the word
//   dm_ready_i        data memory has completed the access
//   tf_true_i         flag-test unit result for the current op_tf_o
//   op_alu_o/op_tf_o/op_se_o   ALU op, flag-test op, sign-extend mode
//   w_im_o/w_pc_o/w_dm_o/w_rb_o write strobes; w_rf_o flag-write mode
//   s_mxpc_o/s_mxrb_o/s_mxse_o datapath mux selects
//   halted_o/fault_o/retired_o status and retired-instruction count
// Modports: slave = control unit, master = environment driving it.
interface multicycle_control_unit_if #(
  parameter int unsigned ALU_OP_W = 5,
  parameter int unsigned TF_W     = 3,
  parameter int unsigned CNT_W    = 16
);
  logic [2:0]          type_i;
  logic [ALU_OP_W-1:0] op_i;
  logic                im_ready_i;
  logic                dm_ready_i;
  logic                tf_true_i;

  logic [ALU_OP_W-1:0] op_alu_o;
  logic [TF_W-1:0]     op_tf_o;
  logic                op_se_o;
  logic                w_im_o;
  logic                w_pc_o;
  logic                w_dm_o;
  logic                w_rb_o;
  logic [2:0]          w_rf_o;
  logic                s_mxpc_o;
  logic [1:0]          s_mxrb_o;
  logic                s_mxse_o;
  logic                halted_o;
  logic                fault_o;
  logic [CNT_W-1:0]    retired_o;

  modport slave (
    input  type_i, op_i, im_ready_i, dm_ready_i, tf_true_i,
    output op_alu_o, op_tf_o, op_se_o, w_im_o, w_pc_o, w_dm_o, w_rb_o, w_rf_o,
           s_mxpc_o, s_mxrb_o, s_mxse_o, halted_o, fault_o, retired_o
  );

  modport master (
    output type_i, op_i, im_ready_i, dm_ready_i, tf_true_i,
    input  op_alu_o, op_tf_o, op_se_o, w_im_o, w_pc_o, w_dm_o, w_rb_o, w_rf_o,
           s_mxpc_o, s_mxrb_o, s_mxse_o, halted_o, fault_o, retired_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle processor control FSM: IF -> ID -> EX -> (MEM for load/store) -> WB -> IF.
// Decodes {type,op} in ID, waits on memory ready handshakes with a watchdog, handles HALT and
// illegal codes, selects the branch target from the flag unit and counts retired instructions.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  synchronous active-low reset
//   bus     control bus (slave modport), see multicycle_control_unit_if
// All outputs are registered from the next state, so they are valid in the cycle the FSM
// occupies the corresponding state. Decode assumes 5-bit op and 3-bit flag-test encodings.
module multicycle_control_unit #(
  parameter int unsigned ALU_OP_W = 5,
  parameter int unsigned TF_W     = 3,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  multicycle_control_unit_if.slave bus
);

  localparam int unsigned      WaitW    = $clog2(WAIT_MAX + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StHalt} state_e;

  state_e              state_q, state_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [ALU_OP_W-1:0] op_alu_q, op_alu_d;
  logic [TF_W-1:0]     op_tf_q, op_tf_d;
  logic                op_se_q, op_se_d;
  logic                s_mxse_q, s_mxse_d;
  logic [1:0]          s_mxrb_q, s_mxrb_d;
  // Decode results latched in ID and consumed in MEM/WB
  logic                rb_en_q, rb_en_d;
  logic [2:0]          rf_mode_q, rf_mode_d;
  logic                mem_q, mem_d;
  logic                store_q, store_d;
  logic                jump_q, jump_d;
  logic                pc_sel_q, pc_sel_d;
  // Registered strobes
  logic                w_im_q, w_im_d;
  logic                w_pc_q, w_pc_d;
  logic                w_dm_q, w_dm_d;
  logic                w_rb_q, w_rb_d;
  logic [2:0]          w_rf_q, w_rf_d;
  logic                s_mxpc_q, s_mxpc_d;
  logic                halted_q, halted_d;

  logic [4:0]          op5;
  logic [2:0]          jump_tf;
  logic [ALU_OP_W-1:0] dec_op_alu;
  logic [TF_W-1:0]     dec_op_tf;
  logic                dec_op_se, dec_s_mxse, dec_rb_en, dec_mem, dec_store, dec_jump;
  logic                dec_halt, dec_illegal;
  logic [1:0]          dec_s_mxrb;
  logic [2:0]          dec_rf_mode;

  assign op5     = bus.op_i[4:0];
  assign jump_tf = {op5[2], op5[3], op5[4]};

  // Instruction decode; illegal codes fall through with every control at zero (NOP).
  always_comb begin
    dec_op_alu  = '0;
    dec_op_tf   = '0;
    dec_op_se   = 1'b0;
    dec_s_mxse  = 1'b0;
    dec_s_mxrb  = 2'b00;
    dec_rb_en   = 1'b0;
    dec_rf_mode = 3'b000;
    dec_mem     = 1'b0;
    dec_store   = 1'b0;
    dec_jump    = 1'b0;
    dec_halt    = 1'b0;
    dec_illegal = 1'b0;
    case (bus.type_i)
      3'b001, 3'b010: begin
        dec_op_alu = bus.op_i;
        dec_op_tf  = TF_W'(3'b111);
        dec_rb_en  = 1'b1;
        dec_s_mxrb = 2'b10;
        if (bus.type_i == 3'b010) begin
          dec_op_se  = 1'b1;
          dec_s_mxse = 1'b1;
        end else if (op5 == 5'b11111) begin
          dec_rf_mode = 3'b000;
        end else if (op5 == 5'b10000) begin
          dec_rf_mode = 3'b001;
        end else if (op5[4:3] == 2'b01) begin
          dec_rf_mode = 3'b011;
        end else if (op5[4:3] == 2'b00) begin
          dec_rf_mode = 3'b100;
        end else begin
          dec_rf_mode = 3'b010;
        end
      end
      3'b100: begin
        dec_op_tf = TF_W'(3'b111);
        dec_mem   = 1'b1;
        if (op5[4]) begin
          dec_store = 1'b1;
        end else begin
          dec_rb_en  = 1'b1;
          dec_s_mxrb = 2'b01;
        end
      end
      3'b000, 3'b110: begin
        dec_op_alu = ALU_OP_W'(5'b10011);
        dec_op_tf  = TF_W'(jump_tf);
        dec_jump   = 1'b1;
        if (bus.type_i == 3'b000) begin
          dec_s_mxse = 1'b1;
        end else begin
          // Jump-and-link writes the return address only for the unconditional test code
          dec_rb_en = (jump_tf == 3'b011);
        end
      end
      3'b111: begin
        if (op5 == 5'b11111) dec_halt = 1'b1;
        else                 dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    op_alu_d  = op_alu_q;
    op_tf_d   = op_tf_q;
    op_se_d   = op_se_q;
    s_mxse_d  = s_mxse_q;
    s_mxrb_d  = s_mxrb_q;
    rb_en_d   = rb_en_q;
    rf_mode_d = rf_mode_q;
    mem_d     = mem_q;
    store_d   = store_q;
    jump_d    = jump_q;
    pc_sel_d  = pc_sel_q;

    case (state_q)
      StIf: begin
        if (bus.im_ready_i) begin
          state_d = StId;
        end else if (wait_q == WaitLast) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StId: begin
        if (dec_halt) begin
          state_d = StHalt;
        end else begin
          state_d   = StEx;
          op_alu_d  = dec_op_alu;
          op_tf_d   = dec_op_tf;
          op_se_d   = dec_op_se;
          s_mxse_d  = dec_s_mxse;
          s_mxrb_d  = dec_s_mxrb;
          rb_en_d   = dec_rb_en;
          rf_mode_d = dec_rf_mode;
          mem_d     = dec_mem;
          store_d   = dec_store;
          jump_d    = dec_jump;
          if (dec_illegal) fault_d = 1'b1;
        end
      end
      StEx: begin
        pc_sel_d = jump_q & bus.tf_true_i;
        state_d  = mem_q ? StMem : StWb;
      end
      StMem: begin
        if (bus.dm_ready_i) begin
          state_d = StWb;
        end else if (wait_q == WaitLast) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWb:    state_d = StIf;
      StHalt:  state_d = StHalt;
      default: state_d = StIf;
    endcase

    if (state_d != state_q) wait_d = '0;
    if (state_d == StWb) retired_d = retired_q + CNT_W'(1);

    w_im_d   = (state_d == StIf);
    w_dm_d   = (state_d == StMem) && store_d;
    w_pc_d   = (state_d == StWb);
    w_rb_d   = (state_d == StWb) && rb_en_d;
    w_rf_d   = (state_d == StWb) ? rf_mode_d : 3'b000;
    s_mxpc_d = (state_d == StWb) && pc_sel_d;
    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIf;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
      op_alu_q  <= '0;
      op_tf_q   <= '0;
      op_se_q   <= 1'b0;
      s_mxse_q  <= 1'b0;
      s_mxrb_q  <= 2'b00;
      rb_en_q   <= 1'b0;
      rf_mode_q <= 3'b000;
      mem_q     <= 1'b0;
      store_q   <= 1'b0;
      jump_q    <= 1'b0;
      pc_sel_q  <= 1'b0;
      // The cycle after reset is already an IF cycle, so the fetch strobe is up
      w_im_q    <= 1'b1;
      w_pc_q    <= 1'b0;
      w_dm_q    <= 1'b0;
      w_rb_q    <= 1'b0;
      w_rf_q    <= 3'b000;
      s_mxpc_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      op_alu_q  <= op_alu_d;
      op_tf_q   <= op_tf_d;
      op_se_q   <= op_se_d;
      s_mxse_q  <= s_mxse_d;
      s_mxrb_q  <= s_mxrb_d;
      rb_en_q   <= rb_en_d;
      rf_mode_q <= rf_mode_d;
      mem_q     <= mem_d;
      store_q   <= store_d;
      jump_q    <= jump_d;
      pc_sel_q  <= pc_sel_d;
      w_im_q    <= w_im_d;
      w_pc_q    <= w_pc_d;
      w_dm_q    <= w_dm_d;
      w_rb_q    <= w_rb_d;
      w_rf_q    <= w_rf_d;
      s_mxpc_q  <= s_mxpc_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.op_alu_o  = op_alu_q;
  assign bus.op_tf_o   = op_tf_q;
  assign bus.op_se_o   = op_se_q;
  assign bus.w_im_o    = w_im_q;
  assign bus.w_pc_o    = w_pc_q;
  assign bus.w_dm_o    = w_dm_q;
  assign bus.w_rb_o    = w_rb_q;
  assign bus.w_rf_o    = w_rf_q;
  assign bus.s_mxpc_o  = s_mxpc_q;
  assign bus.s_mxrb_o  = s_mxrb_q;
  assign bus.s_mxse_o  = s_mxse_q;
  assign bus.halted_o  = halted_q;
  assign bus.fault_o   = fault_q;
  assign bus.retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a table of instructions with expected controls is run
// through the FSM; expected records are queued when an instruction is driven and popped at WB.
// Hand-written sequences cover reset mid-MEM, HALT, illegal codes and the fetch watchdog.
module tb_multicycle_control_unit;

  typedef struct {
    logic [2:0] typ;
    logic [4:0] op;
    logic       tf;
    int         dm_wait;   // MEM cycles with dm_ready low before it rises
    logic [4:0] chk;       // [4] op_tf [3] op_alu [2] op_se [1] s_mxse [0] s_mxrb
    logic [4:0] e_alu;
    logic [2:0] e_tf;
    logic       e_se;
    logic       e_mxse;
    logic [1:0] e_mxrb;
    logic       e_rb;
    logic [2:0] e_rf;
    logic       e_mxpc;
    logic       e_store;
    logic       e_mem;
    logic       e_fault;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_retired = '0;
  vec_t vecs[14];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALU_OP_W(5), .TF_W(3), .CNT_W(16)) bus ();

  multicycle_control_unit #(
    .ALU_OP_W(5),
    .TF_W    (3),
    .WAIT_MAX(15),
    .CNT_W   (16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset for one edge, check the post-reset IF cycle, then release.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.im_ready_i = 1'b0;
    bus.dm_ready_i = 1'b0;
    step();
    chk({tag, ".w_im"}, 32'(bus.w_im_o), 1);
    chk({tag, ".strobes"},
        32'({bus.w_pc_o, bus.w_dm_o, bus.w_rb_o, bus.w_rf_o, bus.s_mxpc_o}), 0);
    chk({tag, ".status"}, 32'({bus.halted_o, bus.fault_o}), 0);
    chk({tag, ".retired"}, 32'(bus.retired_o), 0);
    rst_n = 1'b1;
    exp_retired = '0;
  endtask

  // Called at the negedge of an IF cycle; returns at the negedge of the following IF cycle.
  task automatic run_vec(input string tag, input vec_t v);
    vec_t e;
    int c;
    int dm_cnt;
    int bad_strobe;
    int exp_lat;
    bit got;
    bus.type_i     = v.typ;
    bus.op_i       = v.op;
    bus.tf_true_i  = v.tf;
    bus.im_ready_i = 1'b1;
    bus.dm_ready_i = 1'b0;
    sb_q.push_back(v);
    chk({tag, ".if_w_im"}, 32'(bus.w_im_o), 1);
    c = 0;
    dm_cnt = 0;
    bad_strobe = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      step();
      c++;
      if (c == 2) begin
        if (v.chk[4]) chk({tag, ".ex_op_tf"}, 32'(bus.op_tf_o), 32'(v.e_tf));
        if (v.chk[3]) chk({tag, ".ex_op_alu"}, 32'(bus.op_alu_o), 32'(v.e_alu));
      end
      if (bus.w_dm_o) dm_cnt++;
      if (bus.w_pc_o) begin
        got = 1'b1;
        e = sb_q.pop_front();
        exp_retired = exp_retired + 16'd1;
        exp_lat = e.e_mem ? 4 + e.dm_wait : 3;
        chk({tag, ".latency"}, 32'(c), 32'(exp_lat));
        chk({tag, ".w_rb"}, 32'(bus.w_rb_o), 32'(e.e_rb));
        chk({tag, ".w_rf"}, 32'(bus.w_rf_o), 32'(e.e_rf));
        chk({tag, ".s_mxpc"}, 32'(bus.s_mxpc_o), 32'(e.e_mxpc));
        if (e.chk[4]) chk({tag, ".op_tf"}, 32'(bus.op_tf_o), 32'(e.e_tf));
        if (e.chk[3]) chk({tag, ".op_alu"}, 32'(bus.op_alu_o), 32'(e.e_alu));
        if (e.chk[2]) chk({tag, ".op_se"}, 32'(bus.op_se_o), 32'(e.e_se));
        if (e.chk[1]) chk({tag, ".s_mxse"}, 32'(bus.s_mxse_o), 32'(e.e_mxse));
        if (e.chk[0]) chk({tag, ".s_mxrb"}, 32'(bus.s_mxrb_o), 32'(e.e_mxrb));
        chk({tag, ".fault"}, 32'(bus.fault_o), 32'(e.e_fault));
        chk({tag, ".halted"}, 32'(bus.halted_o), 0);
        chk({tag, ".retired"}, 32'(bus.retired_o), 32'(exp_retired));
        chk({tag, ".w_dm_cycles"}, 32'(dm_cnt), e.e_store ? 32'(e.dm_wait + 1) : 0);
        chk({tag, ".stray_strobes"}, 32'(bad_strobe), 0);
      end else begin
        if (bus.w_rb_o || bus.w_rf_o != 3'b000 || bus.s_mxpc_o) bad_strobe++;
        bus.dm_ready_i = (c >= 3 + v.dm_wait);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.wb_timeout: got no WB within 40 cycles, required WB", tag);
      if (sb_q.size() > 0) sb_q.delete(0);
    end
    step();
    bus.dm_ready_i = 1'b0;
  endtask

  initial begin
    int n_im;
    vec_t v;
    //         typ     op       tf  dw chk       alu       tf     se    mxse  mxrb   rb    rf      pc    st    mem   flt
    vecs[0]  = '{3'b001, 5'b01010, 1'b0, 0, 5'b11111, 5'b01010, 3'b111, 1'b0, 1'b0, 2'b10, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 5'b11111, 1'b0, 0, 5'b11111, 5'b11111, 3'b111, 1'b0, 1'b0, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 5'b10000, 1'b0, 0, 5'b11111, 5'b10000, 3'b111, 1'b0, 1'b0, 2'b10, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 5'b00110, 1'b0, 0, 5'b11111, 5'b00110, 3'b111, 1'b0, 1'b0, 2'b10, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b001, 5'b11000, 1'b0, 0, 5'b11111, 5'b11000, 3'b111, 1'b0, 1'b0, 2'b10, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 5'b00101, 1'b0, 0, 5'b11111, 5'b00101, 3'b111, 1'b1, 1'b1, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 5'b00011, 1'b0, 2, 5'b10001, 5'b00000, 3'b111, 1'b0, 1'b0, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'b100, 5'b10000, 1'b0, 3, 5'b10000, 5'b00000, 3'b111, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{3'b000, 5'b00100, 1'b1, 0, 5'b11010, 5'b10011, 3'b100, 1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b000, 5'b00100, 1'b0, 0, 5'b11010, 5'b10011, 3'b100, 1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 5'b11000, 1'b1, 0, 5'b11011, 5'b10011, 3'b011, 1'b0, 1'b0, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b110, 5'b00100, 1'b0, 0, 5'b11011, 5'b10011, 3'b100, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'b000, 5'b01000, 1'b1, 0, 5'b11010, 5'b10011, 3'b010, 1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'b100, 5'b00000, 1'b0, 0, 5'b10001, 5'b00000, 3'b111, 1'b0, 1'b0, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};

    bus.type_i = 3'b000;
    bus.op_i = 5'b00000;
    bus.tf_true_i = 1'b0;
    bus.im_ready_i = 1'b0;
    bus.dm_ready_i = 1'b0;
    @(negedge clk);
    do_reset("init_rst");

    for (int i = 0; i < 14; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset while a store waits in MEM
    bus.type_i = 3'b100;
    bus.op_i = 5'b10000;
    bus.im_ready_i = 1'b1;
    bus.dm_ready_i = 1'b0;
    repeat (4) step();
    chk("mid_mem.w_dm", 32'(bus.w_dm_o), 1);
    chk("mid_mem.retired_before", 32'(bus.retired_o), 32'(exp_retired));
    do_reset("mid_mem_rst");

    // HALT instruction after one retired instruction
    run_vec("pre_halt", vecs[0]);
    bus.type_i = 3'b111;
    bus.op_i = 5'b11111;
    bus.im_ready_i = 1'b1;
    step();
    step();
    chk("halt.halted", 32'(bus.halted_o), 1);
    chk("halt.w_pc", 32'(bus.w_pc_o), 0);
    chk("halt.fault", 32'(bus.fault_o), 0);
    chk("halt.retired", 32'(bus.retired_o), 32'(exp_retired));
    repeat (3) step();
    chk("halt.stay", 32'(bus.halted_o), 1);
    chk("halt.w_im", 32'(bus.w_im_o), 0);
    chk("halt.retired_late", 32'(bus.retired_o), 32'(exp_retired));

    // Illegal code executes as a PC-only NOP and leaves FAULT set
    do_reset("illegal_rst");
    v = '{3'b011, 5'b00000, 1'b1, 0, 5'b00000, 5'b00000, 3'b000, 1'b0, 1'b0, 2'b00,
          1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    run_vec("illegal", v);
    v = vecs[5];
    v.e_fault = 1'b1;
    run_vec("post_illegal", v);

    // Fetch watchdog
    do_reset("wd_rst");
    n_im = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.halted_o) break;
      if (bus.w_im_o) n_im++;
      step();
    end
    chk("wd.if_cycles", 32'(n_im), 15);
    chk("wd.halted", 32'(bus.halted_o), 1);
    chk("wd.fault", 32'(bus.fault_o), 1);
    bus.im_ready_i = 1'b1;
    repeat (3) step();
    chk("wd.w_im_after", 32'(bus.w_im_o), 0);
    chk("wd.halted_after", 32'(bus.halted_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
